// File: rtl/apple2_disk_pkg.sv
// Shared definitions for the Apple II disk track loader and writer.
package apple2_disk_pkg;

  localparam int unsigned SECTORS_PER_TRACK = 13;
  localparam int unsigned SECTOR_BYTES      = 512;
  localparam int unsigned SECTOR_ADDR_W     = $clog2(SECTOR_BYTES);
  localparam int unsigned TRACK_SEC_W       = $clog2(SECTORS_PER_TRACK);
  localparam int unsigned TRACK_ADDR_W      = TRACK_SEC_W + SECTOR_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    XFER
  } wr_state_t;

endpackage

// File: rtl/sd_ack_edge.sv
// Registers the hps_io sector acknowledge and reports its rising and falling edges.
module sd_ack_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ack_i,
  output logic rise_o,
  output logic fall_o
);

  logic old_ack_d, old_ack_q;

  assign old_ack_d = ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      old_ack_q <= 1'b0;
    end else begin
      old_ack_q <= old_ack_d;
    end
  end

  assign rise_o = ~old_ack_q & ack_i;
  assign fall_o = old_ack_q & ~ack_i;

endmodule

// File: rtl/nib_track_writer.sv
// Write-back engine for the NIB track buffer: tracks modifications and streams the
// buffer to the mounted image one sector at a time through the hps_io write handshake.
module nib_track_writer
  import apple2_disk_pkg::*;
#(
  parameter int unsigned SECTORS = SECTORS_PER_TRACK,
  parameter int unsigned TRACK_W = 6,
  parameter int unsigned SEC_W   = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [TRACK_W-1:0]   track,
  input  logic                 track_we,
  input  logic                 flush_req,
  input  logic [63:0]          img_size,
  input  logic                 img_readonly,
  input  logic                 img_mounted,
  output logic                 busy,
  output logic                 done,
  output logic                 dirty,
  output logic [31:0]          sd_lba,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic [8:0]           sd_buff_addr,
  output logic [7:0]           sd_buff_din,
  output logic [SEC_W+8:0]     tram_addr,
  input  logic [7:0]           tram_dout
);

  wr_state_t          state_d, state_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               dirty_d, dirty_q;
  logic               redirty_d, redirty_q;
  logic               sd_wr_d, sd_wr_q;
  logic [31:0]        sd_lba_d, sd_lba_q;
  logic [SEC_W-1:0]   sec_d, sec_q;
  logic               ack_rise, ack_fall;

  sd_ack_edge u_ack_edge (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .ack_i  (sd_ack),
    .rise_o (ack_rise),
    .fall_o (ack_fall)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dirty_d   = dirty_q;
    redirty_d = redirty_q;
    sd_wr_d   = sd_wr_q;
    sd_lba_d  = sd_lba_q;
    sec_d     = sec_q;

    // Writes landing mid-flush must survive the flush completing.
    if (track_we) begin
      if (busy_q) redirty_d = 1'b1;
      else        dirty_d   = 1'b1;
    end

    if (img_mounted) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      sd_wr_d   = 1'b0;
      dirty_d   = 1'b0;
      redirty_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush_req) begin
            if (!(dirty_q || track_we) || (img_size == 64'd0) || img_readonly) begin
              dirty_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              sd_lba_d = 32'(track) * SECTORS;
              sec_d    = '0;
              sd_wr_d  = 1'b1;
              busy_d   = 1'b1;
              state_d  = WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (ack_rise) begin
            sd_wr_d = 1'b0;
            state_d = XFER;
          end
        end
        XFER: begin
          if (ack_fall) begin
            if (sec_q == SEC_W'(SECTORS - 1)) begin
              dirty_d   = redirty_q | track_we;
              redirty_d = 1'b0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              state_d   = IDLE;
            end else begin
              sec_d    = sec_q + 1'b1;
              sd_lba_d = sd_lba_q + 32'd1;
              sd_wr_d  = 1'b1;
              state_d  = WAIT_ACK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dirty_q   <= 1'b0;
      redirty_q <= 1'b0;
      sd_wr_q   <= 1'b0;
      sd_lba_q  <= 32'd0;
      sec_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dirty_q   <= dirty_d;
      redirty_q <= redirty_d;
      sd_wr_q   <= sd_wr_d;
      sd_lba_q  <= sd_lba_d;
      sec_q     <= sec_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dirty       = dirty_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = sd_lba_q;
  assign sd_buff_din = tram_dout;
  assign tram_addr   = {sec_q, sd_buff_addr};

endmodule

// File: tb/tb_nib_track_writer.sv
// Self-checking bench for nib_track_writer with an hps_io write model and LBA scoreboard.
module tb_nib_track_writer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  track = '0;
  logic        track_we = 1'b0;
  logic        flush_req = 1'b0;
  logic [63:0] img_size = 64'd0;
  logic        img_readonly = 1'b0;
  logic        img_mounted = 1'b0;
  logic        busy, done, dirty, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_din;
  logic [12:0] tram_addr;
  logic [7:0]  tram_dout;

  logic [7:0]  tram [8192];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;

  typedef struct packed {
    logic [31:0] lba;
    logic [3:0]  sec;
  } exp_t;
  exp_t exp_q[$];

  nib_track_writer dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .track        (track),
    .track_we     (track_we),
    .flush_req    (flush_req),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .img_mounted  (img_mounted),
    .busy         (busy),
    .done         (done),
    .dirty        (dirty),
    .sd_lba       (sd_lba),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_din  (sd_buff_din),
    .tram_addr    (tram_addr),
    .tram_dout    (tram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) tram_dout <= tram[tram_addr];

  always @(posedge clk_sys) begin
    if (done)  done_cnt++;
    if (sd_wr) wr_cnt++;
  end

  function automatic logic [7:0] byte_of(input int idx);
    return 8'((idx * 37) ^ (idx >> 7));
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; track_we = 1'b0; flush_req = 1'b0; img_mounted = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
  endtask

  task automatic mark_dirty();
    track_we = 1'b1;
    tick(1);
    track_we = 1'b0;
    tests++;
    if (dirty !== 1'b1) begin
      fails++; $display("FAIL mark_dirty: dirty=%b required 1", dirty);
    end
  endtask

  // Plays one hps_io sector write: wait for sd_wr, ack, walk 512 addresses, drop ack.
  task automatic service_sector(input bit inj_we, input bit inj_mount);
    exp_t e;
    int   waited = 0;
    int   bad = 0;
    int   first_bad = -1;
    logic [7:0] exp_b;
    while (sd_wr !== 1'b1 && waited < 100) begin tick(1); waited++; end
    tests++;
    if (sd_wr !== 1'b1) begin
      fails++; $display("FAIL sd_wr_timeout: sd_wr=%b required 1", sd_wr); return;
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL scoreboard_empty: unexpected sd_wr at lba %0d", sd_lba); return;
    end
    e = exp_q.pop_front();
    tests++;
    if (sd_lba !== e.lba) begin
      fails++; $display("FAIL sd_lba: got %0d required %0d", sd_lba, e.lba);
    end
    sd_ack = 1'b1;
    tick(1);
    tests++;
    if (sd_wr !== 1'b0) begin
      fails++; $display("FAIL sd_wr_drop: sd_wr=%b required 0 after ack", sd_wr);
    end
    for (int a = 0; a <= 512; a++) begin
      if (a > 0 && !inj_mount) begin
        exp_b = byte_of(int'(e.sec) * 512 + a - 1);
        if (sd_buff_din !== exp_b) begin
          bad++;
          if (first_bad < 0) first_bad = a - 1;
        end
      end
      if (a == 101 && inj_mount) begin
        img_mounted = 1'b0;
        tests++;
        if (sd_wr !== 1'b0 || busy !== 1'b0 || dirty !== 1'b0) begin
          fails++;
          $display("FAIL mount_abort: sd_wr=%b busy=%b dirty=%b required 0 0 0",
                   sd_wr, busy, dirty);
        end
      end
      if (a < 512) sd_buff_addr = 9'(a);
      track_we = inj_we && (a == 100);
      if (a == 100 && inj_mount) img_mounted = 1'b1;
      tick(1);
    end
    track_we = 1'b0;
    if (!inj_mount) begin
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL sector_data: lba %0d has %0d bad bytes, first at %0d, required 0",
                 e.lba, bad, first_bad);
      end
    end
    sd_ack = 1'b0;
    tick(1);
  endtask

  // Full dirty flush of a track; checks completion and the resulting dirty state.
  task automatic run_flush(input int trk, input int redirty_sec, input bit exp_dirty);
    int d0;
    track = 6'(trk);
    for (int s = 0; s < 13; s++) exp_q.push_back('{lba: 32'(trk * 13 + s), sec: 4'(s)});
    pulse_flush();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL flush_busy: busy=%b required 1", busy);
    end
    d0 = done_cnt;
    for (int s = 0; s < 13; s++) begin
      service_sector(s == redirty_sec, 1'b0);
      if (s < 12) begin
        tests++;
        if (done !== 1'b0) begin
          fails++; $display("FAIL early_done: done=%b after sector %0d required 0", done, s);
        end
      end
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || dirty !== exp_dirty) begin
      fails++;
      $display("FAIL flush_complete: done=%b busy=%b dirty=%b required 1 0 %b",
               done, busy, dirty, exp_dirty);
    end
    tick(1);
    tests++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL done_pulse: done=%b pulses=%0d required 0 and 1", done,
                        done_cnt - d0);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_left: %0d sectors unwritten, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_quiet_flush(input string name);
    int w0;
    w0 = wr_cnt;
    pulse_flush();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || sd_wr !== 1'b0 || dirty !== 1'b0) begin
      fails++;
      $display("FAIL %s: done=%b busy=%b sd_wr=%b dirty=%b required 1 0 0 0",
               name, done, busy, sd_wr, dirty);
    end
    tick(3);
    tests++;
    if (done !== 1'b0 || wr_cnt != w0) begin
      fails++; $display("FAIL %s_after: done=%b sd_wr_cycles=%0d required 0 0",
                        name, done, wr_cnt - w0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || dirty !== 1'b0 || sd_wr !== 1'b0) begin
      fails++; $display("FAIL reset_flags: busy=%b done=%b dirty=%b sd_wr=%b required 0000",
                        busy, done, dirty, sd_wr);
    end
    tests++;
    if (sd_lba !== 32'd0 || tram_addr !== 13'd0) begin
      fails++; $display("FAIL reset_lba: sd_lba=%0d tram_addr=%0d required 0 0", sd_lba, tram_addr);
    end
  endtask

  task automatic test_clean();
    img_size = 64'd232960; img_readonly = 1'b0;
    check_quiet_flush("clean_flush");
  endtask

  task automatic test_dirty_writeback();
    mark_dirty();
    run_flush(5, -1, 1'b0);
  endtask

  task automatic test_protected();
    img_readonly = 1'b1;
    mark_dirty();
    check_quiet_flush("readonly_flush");
    img_readonly = 1'b0;
    img_size = 64'd0;
    mark_dirty();
    check_quiet_flush("no_image_flush");
    img_size = 64'd232960;
  endtask

  task automatic test_redirty();
    mark_dirty();
    run_flush(10, 7, 1'b1);
    run_flush(10, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    // track_we and flush_req in the same cycle still counts as dirty
    track = 6'd63;
    for (int s = 0; s < 13; s++) exp_q.push_back('{lba: 32'(63 * 13 + s), sec: 4'(s)});
    track_we = 1'b1;
    flush_req = 1'b1;
    tick(1);
    track_we = 1'b0;
    flush_req = 1'b0;
    for (int s = 0; s < 13; s++) service_sector(1'b0, 1'b0);
    tests++;
    if (done !== 1'b1 || dirty !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL same_cycle_flush: done=%b dirty=%b left=%0d required 1 0 0",
                        done, dirty, exp_q.size());
    end
    exp_q.delete();
    tick(1);
  endtask

  task automatic test_mount_abort();
    int d0, w0;
    mark_dirty();
    track = 6'd2;
    for (int s = 0; s < 13; s++) exp_q.push_back('{lba: 32'(2 * 13 + s), sec: 4'(s)});
    pulse_flush();
    d0 = done_cnt;
    for (int s = 0; s < 3; s++) service_sector(1'b0, 1'b0);
    service_sector(1'b0, 1'b1);
    w0 = wr_cnt;
    tick(20);
    tests++;
    if (done_cnt != d0 || wr_cnt != w0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_quiet: done_pulses=%0d sd_wr_cycles=%0d busy=%b required 0 0 0",
                        done_cnt - d0, wr_cnt - w0, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int waited = 0;
    mark_dirty();
    track = 6'd1;
    pulse_flush();
    while (sd_wr !== 1'b1 && waited < 20) begin tick(1); waited++; end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (sd_wr !== 1'b0 || busy !== 1'b0 || dirty !== 1'b0) begin
      fails++; $display("FAIL async_reset: sd_wr=%b busy=%b dirty=%b required 0 0 0",
                        sd_wr, busy, dirty);
    end
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check_quiet_flush("post_reset_flush");
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) tram[i] = byte_of(i);
    test_reset();
    test_clean();
    test_dirty_writeback();
    test_protected();
    test_redirty();
    test_back_to_back();
    test_mount_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nib_track_writer.md
Name: nib_track_writer

Overview:
- Write-back engine for the NIB floppy track buffer.
- Tracks whether the 13-sector (6656-byte) track buffer was modified by the disk controller.
- On a flush request, streams the buffer back to the mounted image through the hps_io SD write handshake (sd_wr/sd_ack/sd_buff_addr/sd_buff_din), one 512-byte sector at a time.
- Sits beside the track loader. The loader issues flush_req before fetching a new track and waits for done.

Parameters:
- SECTORS, 13, 512-byte sectors per NIB track.
- TRACK_W, 6, width of the track number.
- SEC_W, 4, sector index width; must satisfy 2^SEC_W >= SECTORS.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- track  in  TRACK_W  track number currently held in the buffer; sampled at flush start.
- track_we  in  1  disk controller wrote a byte into the track buffer; marks it dirty.
- flush_req  in  1  single-cycle request to write back the buffer if dirty.
- img_size  in  64  mounted image size; 0 = no image.
- img_readonly  in  1  image is write-protected.
- img_mounted  in  1  pulse: new image mounted.
- busy  out  1  write-back in progress; loader and CPU must stall.
- done  out  1  single-cycle pulse: flush_req fully serviced.
- dirty  out  1  buffer holds unsaved data.
- sd_lba  out  32  LBA of the current sector.
- sd_wr  out  1  SD write request to hps_io.
- sd_ack  in  1  hps_io sector-transfer acknowledge.
- sd_buff_addr  in  9  byte index within the sector, driven by hps_io.
- sd_buff_din  out  8  byte to hps_io.
- tram_addr  out  SEC_W+9  track RAM read address = {sec, sd_buff_addr}.
- tram_dout  in  8  track RAM read data; 1-cycle synchronous latency.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, dirty=0, sd_wr=0, sd_lba=0, sec=0, redirty=0.
- Edge detect: old_ack register; rise = ~old_ack & sd_ack, fall = old_ack & ~sd_ack.
- sd_buff_din = tram_dout, combinational pass-through. The RAM's 1-cycle latency matches the hps_io write-data timing.
- tram_addr is combinational from the sec register and sd_buff_addr.
- Dirty tracking:
  - In IDLE, track_we sets dirty.
  - While busy, track_we sets redirty instead.
- IDLE, on flush_req:
  - dirty=0, or img_size==0, or img_readonly=1: clear dirty, pulse done the next cycle, stay IDLE.
  - Otherwise: latch the track; sd_lba = track*SECTORS (zero-extended to 32 bits); sec=0; sd_wr=1; busy=1; go to WAIT_ACK.
- WAIT_ACK: on rise, drop sd_wr=0 and go to XFER. sd_wr stays asserted until rise.
- XFER, on fall:
  - sec < SECTORS-1: sec+1, sd_lba+1, sd_wr=1, go to WAIT_ACK.
  - sec == SECTORS-1: dirty=redirty, redirty=0, busy=0, done=1 for one cycle, go to IDLE.
- img_mounted in any state:
  - Abort: sd_wr=0, busy=0, dirty=0, redirty=0, go to IDLE. No done pulse.
  - A transfer already acked by hps_io runs to completion on the hps side; the writer ignores its fall.
- flush_req while busy is ignored. The requester must wait for done.
- Simultaneous flush_req and track_we in IDLE: dirty counts as set, so the flush proceeds.
- Latency, clean flush: done asserted 1 cycle after flush_req.
- Latency, dirty flush: done asserted 1 cycle after the 13th ack fall.
- Arithmetic: sd_lba increments modulo 2^32. The sec counter never exceeds SECTORS-1.

Decomposition:
- Package apple2_disk_pkg holds:
  - SECTORS_PER_TRACK = 13;
  - SECTOR_BYTES = 512;
  - the track buffer address width;
  - typedef wr_state_t {IDLE, WAIT_ACK, XFER}.
- The loader shares the same package.
- One sub-module, sd_ack_edge: registers sd_ack and outputs rise/fall pulses; reusable by the loader.
- Everything else is inline.

Test Plan:
- Clean flush: reset, pulse flush_req with dirty=0 → no sd_wr; done=1 exactly one cycle later; busy stays 0.
- Dirty write-back, track=5, img_size=232960:
  - Pulse track_we, then flush_req.
  - Expect sd_wr with sd_lba=65 first, then 66..77 across 13 ack cycles.
  - hps model reads bytes tram[{sec,addr}] correctly with 1-cycle latency.
  - After the last fall: done=1, dirty=0.
- Protected image: img_readonly=1, dirty=1, flush_req → no sd_wr; dirty=0; done pulse.
- Redirty during flush: track_we asserted during sector 7 → dirty=1 after done. A second flush rewrites all 13 sectors.
- Mount abort: img_mounted during sector 3 → sd_wr=0, busy=0, dirty=0 within 1 cycle; no done.
- Async reset mid-transfer: reset_n=0 during WAIT_ACK → sd_wr, busy, dirty all 0 immediately without a clock edge. After release, a flush_req produces done with no sd_wr.
